// File: rtl/zbuf_mem_scheduler_if.sv
// Pixel request, clear control and SRAM bus between the z-buffer scheduler and its environment.
// The master modport is the scheduler side; the slave modport is the rasterizer/SRAM/video side.
interface zbuf_mem_scheduler_if;
    logic        iVIDEO_ON;
    logic        iCLR_REQ;
    logic        oCLR_BUSY;
    logic        oCLR_DONE;
    logic        iPIX_VALID;
    logic [9:0]  iPIX_X;
    logic [8:0]  iPIX_Y;
    logic [15:0] iPIX_DATA;
    logic        oPIX_READY;
    logic        oPIX_REJECT;
    logic [17:0] oMEM_ADDR;
    logic [15:0] oMEM_DATA;
    logic        oMEM_READ;
    logic        oMEM_WRITE;
    logic [15:0] iMEM_DATA;

    modport master (
        input  iVIDEO_ON, iCLR_REQ, iPIX_VALID, iPIX_X, iPIX_Y, iPIX_DATA, iMEM_DATA,
        output oCLR_BUSY, oCLR_DONE, oPIX_READY, oPIX_REJECT,
               oMEM_ADDR, oMEM_DATA, oMEM_READ, oMEM_WRITE
    );

    modport slave (
        output iVIDEO_ON, iCLR_REQ, iPIX_VALID, iPIX_X, iPIX_Y, iPIX_DATA, iMEM_DATA,
        input  oCLR_BUSY, oCLR_DONE, oPIX_READY, oPIX_REJECT,
               oMEM_ADDR, oMEM_DATA, oMEM_READ, oMEM_WRITE
    );
endinterface

// File: rtl/zbuf_mem_scheduler.sv
// SRAM scheduler for a 640x400 framebuffer: bulk clear during blanking and per-pixel
// depth-tested read/compare/write. Every output except oPIX_READY is a register.
module zbuf_mem_scheduler #(
    parameter int unsigned CLR_WORDS = 256000
) (
    input  logic                  iCLK,
    input  logic                  reset,
    zbuf_mem_scheduler_if.master  bus
);
    localparam logic [17:0] CLR_LAST  = 18'(CLR_WORDS - 1);
    localparam logic [15:0] CLR_VALUE = 16'hC000;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ZREAD, S_ZCMP, S_ZWRITE} state_t;

    state_t      state, state_n;
    logic        clr_pend, clr_pend_n;
    logic [17:0] clr_cnt, clr_cnt_n;
    logic        clr_last, clr_last_n;

    logic [17:0] mem_addr_q, mem_addr_n;
    logic [15:0] mem_data_q, mem_data_n;
    logic        mem_read_q, mem_read_n;
    logic        mem_write_q, mem_write_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        reject_q, reject_n;

    logic [17:0] pix_addr;
    logic [15:0] pix_data;

    logic        pix_ready;
    logic        pix_accept;
    logic        on_screen;
    logic        depth_ok;
    logic [17:0] req_addr;

    // Y*640 + X as (Y<<9) + (Y<<7) + X
    assign req_addr   = {bus.iPIX_Y, 9'd0} + {2'd0, bus.iPIX_Y, 7'd0} + {8'd0, bus.iPIX_X};
    assign on_screen  = (bus.iPIX_X < 10'd640) && (bus.iPIX_Y < 9'd400);
    // A clear request arriving this cycle already blocks pixels so the clear wins the tie
    assign pix_ready  = !reset && (state == S_IDLE) && !bus.iVIDEO_ON && !clr_pend && !bus.iCLR_REQ;
    assign pix_accept = bus.iPIX_VALID && pix_ready;
    assign depth_ok   = pix_data[15:14] <= bus.iMEM_DATA[15:14];

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            clr_pend    <= 1'b0;
            clr_cnt     <= '0;
            clr_last    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            state       <= state_n;
            clr_pend    <= clr_pend_n;
            clr_cnt     <= clr_cnt_n;
            clr_last    <= clr_last_n;
            mem_addr_q  <= mem_addr_n;
            mem_data_q  <= mem_data_n;
            mem_read_q  <= mem_read_n;
            mem_write_q <= mem_write_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            reject_q    <= reject_n;
        end
    end

    // Pixel latch is pure datapath; it is only consumed after an accept reloads it
    always_ff @(posedge iCLK) begin
        if (pix_accept) begin
            pix_addr <= req_addr;
            pix_data <= bus.iPIX_DATA;
        end
    end

    always_comb begin
        state_n    = state;
        clr_pend_n = clr_pend || (bus.iCLR_REQ && state != S_CLEAR);
        case (state)
            S_IDLE: begin
                if (clr_pend && !bus.iVIDEO_ON) begin
                    state_n    = S_CLEAR;
                    clr_pend_n = 1'b0;
                end else if (pix_accept && on_screen) begin
                    state_n = S_ZREAD;
                end
            end
            S_CLEAR:  if (clr_last) state_n = S_IDLE;
            S_ZREAD:  state_n = S_ZCMP;
            S_ZCMP:   state_n = depth_ok ? S_ZWRITE : S_IDLE;
            S_ZWRITE: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_n  = mem_addr_q;
        mem_data_n  = mem_data_q;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        busy_n      = busy_q;
        done_n      = 1'b0;
        reject_n    = 1'b0;
        clr_cnt_n   = clr_cnt;
        clr_last_n  = clr_last;
        case (state)
            S_IDLE: begin
                if (clr_pend && !bus.iVIDEO_ON) begin
                    busy_n = 1'b1;
                end else if (pix_accept) begin
                    if (on_screen) begin
                        mem_read_n = 1'b1;
                        mem_addr_n = req_addr;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                // The final write is shown for one cycle while still in CLEAR, then we finish
                if (clr_last) begin
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    clr_last_n = 1'b0;
                end else if (!bus.iVIDEO_ON) begin
                    mem_write_n = 1'b1;
                    mem_addr_n  = clr_cnt;
                    mem_data_n  = CLR_VALUE;
                    if (clr_cnt == CLR_LAST) begin
                        clr_cnt_n  = '0;
                        clr_last_n = 1'b1;
                    end else begin
                        clr_cnt_n = clr_cnt + 18'd1;
                    end
                end
            end
            S_ZCMP: begin
                if (depth_ok) begin
                    mem_write_n = 1'b1;
                    mem_addr_n  = pix_addr;
                    mem_data_n  = pix_data;
                end else begin
                    reject_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.oMEM_ADDR   = mem_addr_q;
    assign bus.oMEM_DATA   = mem_data_q;
    assign bus.oMEM_READ   = mem_read_q;
    assign bus.oMEM_WRITE  = mem_write_q;
    assign bus.oCLR_BUSY   = busy_q;
    assign bus.oCLR_DONE   = done_q;
    assign bus.oPIX_REJECT = reject_q;
    assign bus.oPIX_READY  = pix_ready;
endmodule
